// File: rtl/fpu_csr_pkg.sv
// Shared constants and types for the floating-point CSR endpoint (fflags/frm/fcsr).
package fpu_csr_pkg;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StResp  = 2'd2
  } fcsr_state_e;

  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

endpackage

// File: rtl/fp_inflight_counter.sv
// Saturating up/down count of FP instructions issued but not yet retired.
module fp_inflight_counter #(
  parameter int unsigned MaxCount = 7,
  localparam int unsigned CntW = $clog2(MaxCount + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [CntW-1:0] o_count,
  output logic            o_full
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxCount);

  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;

  // Simultaneous inc/dec cancel; a decrement at zero is a protocol error and is absorbed.
  always_comb begin
    w_count_d = r_count;
    if (i_inc && !i_dec && (r_count != CntMax)) begin
      w_count_d = r_count + CntW'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CntMax);

endmodule

// File: rtl/fcsr_unit.sv
// FP control/status register holder and CSR access endpoint with flag accrual.
// Build option FCSR_DRAIN_EN: CSR accesses wait for all in-flight FP instructions to retire.
module fcsr_unit
  import fpu_csr_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_req_valid,
  output logic        csr_req_ready,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_mode,
  input  logic [31:0] csr_wdata,
  output logic        csr_rsp_valid,
  input  logic        csr_rsp_ready,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        fp_issue,
  output logic        fp_issue_ready,
  input  logic        fp_retire,
  input  logic [4:0]  fp_flags,
  output logic [4:0]  fflags,
  output logic [2:0]  frm,
  output logic        frm_illegal
);

  fcsr_state_e r_state, w_state_d;
  logic [11:0] r_addr;
  csr_mode_e   r_mode;
  logic [7:0]  r_wdata;
  logic [4:0]  r_fflags, w_fflags_d;
  logic [2:0]  r_frm, w_frm_d;
  logic [7:0]  r_rdata;
  logic        r_illegal;

  logic       w_idle, w_drain_done, w_access, w_legal, w_write;
  logic [7:0] w_old, w_new;

  assign w_idle = (r_state == StIdle);

`ifdef FCSR_DRAIN_EN
  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
  logic [CntW-1:0] w_count;
  logic            w_full;
  logic            w_issue;
  logic            w_unused;

  assign w_issue = fp_issue && fp_issue_ready;

  fp_inflight_counter #(
    .MaxCount(MAX_INFLIGHT)
  ) u_inflight (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_issue),
    .i_dec  (fp_retire),
    .o_count(w_count),
    .o_full (w_full)
  );

  assign w_drain_done   = (w_count == '0) && !fp_retire;
  assign fp_issue_ready = w_idle && !w_full;
  assign w_unused       = ^csr_wdata[31:8];
`else
  logic w_unused;

  assign w_drain_done   = 1'b1;
  assign fp_issue_ready = w_idle;
  assign w_unused       = ^{csr_wdata[31:8], fp_issue, (MAX_INFLIGHT != 0)};
`endif

  assign w_access = (r_state == StDrain) && w_drain_done;
  assign w_write  = w_access && w_legal && (r_mode != CSR_NONE);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (csr_req_valid) w_state_d = StDrain;
      StDrain: if (w_drain_done) w_state_d = StResp;
      StResp:  if (csr_rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_legal = 1'b1;
    w_old   = '0;
    case (r_addr)
      CSR_FFLAGS: w_old = {3'b000, r_fflags};
      CSR_FRM:    w_old = {5'b00000, r_frm};
      CSR_FCSR:   w_old = {r_frm, r_fflags};
      default:    w_legal = 1'b0;
    endcase
    w_new = w_old;
    unique case (r_mode)
      CSR_RW:   w_new = r_wdata;
      CSR_RS:   w_new = w_old | r_wdata;
      CSR_RC:   w_new = w_old & ~r_wdata;
      CSR_NONE: w_new = w_old;
    endcase
  end

  // A CSR write owns the fields it targets; any other flags retiring that cycle still accrue.
  always_comb begin
    w_fflags_d = fp_retire ? (r_fflags | fp_flags) : r_fflags;
    w_frm_d    = r_frm;
    if (w_write) begin
      if (r_addr == CSR_FRM) begin
        w_frm_d = w_new[2:0];
      end else if (r_addr == CSR_FCSR) begin
        w_fflags_d = w_new[FLAG_NV:FLAG_NX];
        w_frm_d    = w_new[7:5];
      end else begin
        w_fflags_d = w_new[FLAG_NV:FLAG_NX];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_mode    <= CSR_NONE;
      r_wdata   <= '0;
      r_fflags  <= '0;
      r_frm     <= '0;
      r_rdata   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_fflags <= w_fflags_d;
      r_frm    <= w_frm_d;
      if (w_idle && csr_req_valid) begin
        r_addr  <= csr_addr;
        r_mode  <= csr_mode_e'(csr_mode);
        r_wdata <= csr_wdata[7:0];
      end
      if (w_access) begin
        r_rdata   <= w_old;
        r_illegal <= !w_legal;
      end
    end
  end

  assign csr_req_ready = w_idle;
  assign csr_rsp_valid = (r_state == StResp);
  assign csr_rdata     = {24'h000000, r_rdata};
  assign csr_illegal   = r_illegal;
  assign fflags        = r_fflags;
  assign frm           = r_frm;
  assign frm_illegal   = (r_frm >= 3'd5);

endmodule

// File: tb/tb_fcsr_unit.sv
// Directed bench for fcsr_unit: a behavioural model checked every cycle plus literal pins.
module tb_fcsr_unit;

  localparam int unsigned MaxInflight = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req_valid, csr_req_ready;
  logic [11:0] csr_addr;
  logic [1:0]  csr_mode;
  logic [31:0] csr_wdata;
  logic        csr_rsp_valid, csr_rsp_ready;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        fp_issue, fp_issue_ready, fp_retire;
  logic [4:0]  fp_flags, fflags;
  logic [2:0]  frm;
  logic        frm_illegal;

  fcsr_unit #(
    .MAX_INFLIGHT(MaxInflight)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .csr_req_valid (csr_req_valid),
    .csr_req_ready (csr_req_ready),
    .csr_addr      (csr_addr),
    .csr_mode      (csr_mode),
    .csr_wdata     (csr_wdata),
    .csr_rsp_valid (csr_rsp_valid),
    .csr_rsp_ready (csr_rsp_ready),
    .csr_rdata     (csr_rdata),
    .csr_illegal   (csr_illegal),
    .fp_issue      (fp_issue),
    .fp_issue_ready(fp_issue_ready),
    .fp_retire     (fp_retire),
    .fp_flags      (fp_flags),
    .fflags        (fflags),
    .frm           (frm),
    .frm_illegal   (frm_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: a request is either pending (busy) or being answered (resp).
  bit m_busy, m_resp, m_illegal;
  int m_addr, m_mode, m_wdata, m_fflags, m_frm, m_rdata, m_count;

  function automatic bit legal_addr(input int addr);
    return (addr >= 1) && (addr <= 3);
  endfunction

  function automatic int csr_value(input int addr, input int ff, input int rm);
    case (addr)
      1:       return ff;
      2:       return rm;
      3:       return rm * 32 + ff;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_issue_ready();
`ifdef FCSR_DRAIN_EN
    return !m_busy && !m_resp && (m_count != int'(MaxInflight));
`else
    return !m_busy && !m_resp;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit accept, inc, drain_ok;
    int flags_now, old, nv;
    if (rst) begin
      m_busy = 0; m_resp = 0; m_illegal = 0;
      m_addr = 0; m_mode = 0; m_wdata = 0;
      m_fflags = 0; m_frm = 0; m_rdata = 0; m_count = 0;
    end else begin
      accept    = csr_req_valid && !m_busy && !m_resp;
      inc       = fp_issue && exp_issue_ready();
      flags_now = fp_retire ? (m_fflags | int'(fp_flags)) : m_fflags;
`ifdef FCSR_DRAIN_EN
      drain_ok = (m_count == 0) && !fp_retire;
`else
      drain_ok = 1;
`endif
      if (m_resp && csr_rsp_ready) m_resp = 0;
      if (m_busy && drain_ok) begin
        old = csr_value(m_addr, m_fflags, m_frm);
        case (m_mode)
          1:       nv = m_wdata;
          2:       nv = old | m_wdata;
          3:       nv = old & ~m_wdata;
          default: nv = old;
        endcase
        m_rdata   = old;
        m_illegal = !legal_addr(m_addr);
        if (legal_addr(m_addr) && m_mode != 0) begin
          if (m_addr == 1 || m_addr == 3) flags_now = nv & 31;
          if (m_addr == 2) m_frm = nv & 7;
          if (m_addr == 3) m_frm = (nv >> 5) & 7;
        end
        m_busy = 0;
        m_resp = 1;
      end
      m_fflags = flags_now;
      if (inc && !fp_retire) m_count++;
      else if (fp_retire && !inc && m_count > 0) m_count--;
      if (accept) begin
        m_busy  = 1;
        m_addr  = int'(csr_addr);
        m_mode  = int'(csr_mode);
        m_wdata = int'(csr_wdata & 32'hFF);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", int'(csr_req_ready), int'(!m_busy && !m_resp));
      chk("rsp_valid", int'(csr_rsp_valid), int'(m_resp));
      if (m_resp) begin
        chk("rdata", int'(csr_rdata), m_rdata);
        chk("illegal", int'(csr_illegal), int'(m_illegal));
      end
      chk("fflags", int'(fflags), m_fflags);
      chk("frm", int'(frm), m_frm);
      chk("frm_illegal", int'(frm_illegal), int'(m_frm >= 5));
      chk("issue_ready", int'(fp_issue_ready), int'(exp_issue_ready()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csr_req(input int addr, input int mode, input logic [31:0] wd);
    csr_req_valid = 1'b1;
    csr_addr      = 12'(addr);
    csr_mode      = 2'(mode);
    csr_wdata     = wd;
    @(negedge clk);
    csr_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int rd, output int ill);
    lat = 0;
    while (!csr_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_arrives", int'(csr_rsp_valid), 1);
    rd  = int'(csr_rdata);
    ill = int'(csr_illegal);
  endtask

  task automatic consume();
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic retire(input int flags);
    fp_retire = 1'b1;
    fp_flags  = 5'(flags);
    @(negedge clk);
    fp_retire = 1'b0;
    fp_flags  = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, rd, ill;
    rst = 1'b1;
    csr_req_valid = 0; csr_addr = 0; csr_mode = 0; csr_wdata = 0; csr_rsp_ready = 0;
    fp_issue = 0; fp_retire = 0; fp_flags = 0;
    cyc(2);
    rst = 1'b0;
    chk("rst_req_ready", int'(csr_req_ready), 1);
    chk("rst_rsp_valid", int'(csr_rsp_valid), 0);
    chk("rst_rdata", int'(csr_rdata), 0);
    chk("rst_illegal", int'(csr_illegal), 0);
    chk("rst_fflags", int'(fflags), 0);
    chk("rst_frm", int'(frm), 0);
    chk("rst_issue_ready", int'(fp_issue_ready), 1);
    chk("rst_frm_illegal", int'(frm_illegal), 0);

    // Plain fcsr read: response one cycle after the accept cycle.
    csr_req(3, 0, 32'h0);
    wait_rsp(lat, rd, ill);
    chk("t1_latency", lat, 1);
    chk("t1_rdata", rd, 0);
    chk("t1_illegal", ill, 0);
    consume();

    // Accrue three flags, then read fflags.
    fp_issue = 1'b1; cyc(3); fp_issue = 1'b0;
    retire(5'h01); retire(5'h04); retire(5'h10);
    csr_req(1, 0, 32'h0);
    wait_rsp(lat, rd, ill);
    chk("t2_rdata", rd, 'h15);
    consume();

    // Read while instructions are still in flight and retiring.
    fp_issue = 1'b1; cyc(2); fp_issue = 1'b0;
    csr_req_valid = 1'b1; csr_addr = 12'h001; csr_mode = 2'd0; csr_wdata = 0;
    @(negedge clk);
    csr_req_valid = 1'b0;
    chk("drain_issue_ready", int'(fp_issue_ready), 0);
    retire(5'h02); retire(5'h08);
    wait_rsp(lat, rd, ill);
`ifdef FCSR_DRAIN_EN
    chk("t2b_rdata", rd, 'h1F);
`else
    chk("t2b_rdata", rd, 'h15);
`endif
    consume();
    csr_req(1, 1, 32'h0);
    wait_rsp(lat, rd, ill);
    chk("t2c_rdata", rd, 'h1F);
    consume();
    chk("t2c_fflags", int'(fflags), 0);

    // Stray retire with nothing in flight still accrues its flags.
    retire(5'h03);
    csr_req(2, 1, 32'hFFFF_FFFE);
    wait_rsp(lat, rd, ill);
    chk("t3_rdata", rd, 0);
    consume();
    chk("t3_frm", int'(frm), 6);
    chk("t3_frm_illegal", int'(frm_illegal), 1);
    csr_req(3, 3, 32'hE0);
    wait_rsp(lat, rd, ill);
    chk("t3b_rdata", rd, 'hC3);
    consume();
    chk("t3b_frm", int'(frm), 0);
    chk("t3b_fflags", int'(fflags), 3);

    // Retire right behind a set: write owns its field, other fields still accrue.
    csr_req(1, 2, 32'h10);
    retire(5'h04);
    wait_rsp(lat, rd, ill);
    consume();
`ifdef FCSR_DRAIN_EN
    chk("t4_fflags", int'(fflags), 'h17);
`else
    chk("t4_fflags", int'(fflags), 'h13);
`endif
    csr_req(2, 1, 32'h1);
    retire(5'h08);
    wait_rsp(lat, rd, ill);
    consume();
    chk("t4b_frm", int'(frm), 1);

    // Unsupported address.
    csr_req(12'h7C0, 1, 32'hFF);
    wait_rsp(lat, rd, ill);
    chk("t5_rdata", rd, 0);
    chk("t5_illegal", ill, 1);
    consume();
    chk("t5_frm", int'(frm), 1);

    // Response back-pressure.
    csr_req(2, 0, 32'h0);
    wait_rsp(lat, rd, ill);
    cyc(5);
    chk("t6_rsp_held", int'(csr_rsp_valid), 1);
    chk("t6_req_ready", int'(csr_req_ready), 0);
    chk("t6_rdata", int'(csr_rdata), 1);
    consume();

    // Fill the in-flight window, then drain with overlapping issue/retire.
    fp_issue = 1'b1; cyc(9);
    fp_retire = 1'b1; cyc(2);
    fp_issue = 1'b0; cyc(8);
    fp_retire = 1'b0; cyc(1);

    // Reset while a fflags write is pending.
    csr_req(1, 1, 32'h1F);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t8_fflags", int'(fflags), 0);
    chk("t8_rsp_valid", int'(csr_rsp_valid), 0);
    chk("t8_req_ready", int'(csr_req_ready), 1);
    cyc(3);
    chk("t8_fflags_later", int'(fflags), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
